// File: rtl/ctrl_pkg.sv
// Shared state encoding and error codes for the path-search sequencing controller.
package ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE              = 3'd0,
    INICIALIZAR       = 3'd1,
    TEM_ATIVO         = 3'd2,
    ATUALIZAR_BUFFER  = 3'd3,
    EXPANDIR          = 3'd4,
    CONSTRUIR_CAMINHO = 3'd5,
    PRONTO            = 3'd6,
    FALHA             = 3'd7
  } estado_t;

  localparam logic [1:0] ERR_NONE        = 2'd0;
  localparam logic [1:0] ERR_SEM_CAMINHO = 2'd1;
  localparam logic [1:0] ERR_LIMITE_ITER = 2'd2;
  localparam logic [1:0] ERR_WATCHDOG    = 2'd3;

endpackage

// File: rtl/coletor_canais.sv
// Sticky per-channel completion flags for one expansion round; reports when every
// masked channel has finished, counting the current-cycle pulse as well.
module coletor_canais #(
  parameter int NUM_CANAIS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [NUM_CANAIS-1:0] mask,
  input  logic [NUM_CANAIS-1:0] lvv_pronto_in,
  output logic                  todos_prontos
);

  logic [NUM_CANAIS-1:0] feitos;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      feitos <= '0;
    end else if (clear) begin
      feitos <= '0;
    end else if (enable) begin
      feitos <= feitos | (lvv_pronto_in & mask);
    end
  end

  assign todos_prontos = ((feitos | lvv_pronto_in) & mask) == mask;

endmodule

// File: rtl/controlador_maquina_estados_multi.sv
// Sequencing FSM for the path search: AA evaluation, multi-channel LVV dispatch,
// path construction and failure exits. Optional watchdog enabled by CTRL_WATCHDOG_EN.
module controlador_maquina_estados_multi
  import ctrl_pkg::*;
#(
  parameter int NUM_CANAIS = 4,
  parameter int CNT_WIDTH  = 8,
  parameter int ITER_WIDTH = 16,
  parameter int MAX_ITER   = 1000,
  parameter int WDT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iniciar_in,
  input  logic                  abortar_in,
  input  logic                  tem_ativo_in,
  input  logic                  aa_pronto_in,
  input  logic [CNT_WIDTH-1:0]  qtd_ativos_in,
  input  logic                  destino_encontrado_in,
  input  logic [NUM_CANAIS-1:0] lvv_pronto_in,
  input  logic                  caminho_pronto_in,
  input  logic                  lido_in,
  output logic                  aguardando_out,
  output logic                  iniciar_out,
  output logic                  atualizar_buffer_out,
  output logic [NUM_CANAIS-1:0] expandir_out,
  output logic                  construir_caminho_out,
  output logic                  caminho_pronto_out,
  output logic                  falha_out,
  output logic [1:0]            erro_out,
  output logic [ITER_WIDTH-1:0] iteracoes_out
);

  if (NUM_CANAIS < 1 || NUM_CANAIS > 16 || MAX_ITER < 1 || WDT_CYCLES < 1) begin : g_param_invalido
    $error("controlador_maquina_estados_multi: invalid parameter set");
  end

  localparam logic [ITER_WIDTH-1:0] MAX_ITER_V = ITER_WIDTH'(MAX_ITER);

  estado_t               estado;
  logic [NUM_CANAIS-1:0] mascara;
  logic                  todos_prontos;
  logic                  limpar_canais;
  logic [ITER_WIDTH-1:0] iter_prox;

`ifdef CTRL_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_LIMITE = WDT_W'(WDT_CYCLES - 1);
  logic [WDT_W-1:0] wdt;
`endif

  // Lowest k channels, k = qtd clamped to [1, NUM_CANAIS]; channel 0 is always used.
  function automatic logic [NUM_CANAIS-1:0] calc_mascara(input logic [CNT_WIDTH-1:0] qtd);
    logic [NUM_CANAIS-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NUM_CANAIS; i++) begin
      m[i] = (i == 0) || (32'(qtd) > i);
    end
    return m;
  endfunction

  assign iter_prox     = iteracoes_out + ITER_WIDTH'(1);
  assign limpar_canais = (estado != EXPANDIR) || todos_prontos || iniciar_in || abortar_in;

  coletor_canais #(
    .NUM_CANAIS (NUM_CANAIS)
  ) u_coletor (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (limpar_canais),
    .enable        (estado == EXPANDIR),
    .mask          (mascara),
    .lvv_pronto_in (lvv_pronto_in),
    .todos_prontos (todos_prontos)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      estado        <= IDLE;
      mascara       <= '0;
      expandir_out  <= '0;
      erro_out      <= ERR_NONE;
      iteracoes_out <= '0;
`ifdef CTRL_WATCHDOG_EN
      wdt           <= '0;
`endif
    end else begin
      expandir_out <= '0;
`ifdef CTRL_WATCHDOG_EN
      // Cleared on every cycle that does not explicitly keep counting in a watched state.
      wdt          <= '0;
`endif
      if (iniciar_in) begin
        estado        <= INICIALIZAR;
        mascara       <= '0;
        erro_out      <= ERR_NONE;
        iteracoes_out <= '0;
      end else if (abortar_in) begin
        estado <= IDLE;
      end else begin
        case (estado)
          IDLE: ;
          INICIALIZAR: begin
            if (aa_pronto_in && tem_ativo_in) estado <= TEM_ATIVO;
          end
          TEM_ATIVO: begin
            if (aa_pronto_in) begin
              if (tem_ativo_in) begin
                estado  <= ATUALIZAR_BUFFER;
                mascara <= calc_mascara(qtd_ativos_in);
              end else if (destino_encontrado_in) begin
                estado <= CONSTRUIR_CAMINHO;
              end else begin
                estado   <= FALHA;
                erro_out <= ERR_SEM_CAMINHO;
              end
            end
          end
          ATUALIZAR_BUFFER: begin
            estado       <= EXPANDIR;
            expandir_out <= mascara;
          end
          EXPANDIR: begin
            if (todos_prontos) begin
              iteracoes_out <= iter_prox;
              if (iter_prox == MAX_ITER_V) begin
                estado   <= FALHA;
                erro_out <= ERR_LIMITE_ITER;
              end else begin
                estado <= TEM_ATIVO;
              end
            end
`ifdef CTRL_WATCHDOG_EN
            else if (wdt == WDT_LIMITE) begin
              estado   <= FALHA;
              erro_out <= ERR_WATCHDOG;
            end else begin
              wdt <= wdt + WDT_W'(1);
            end
`endif
          end
          CONSTRUIR_CAMINHO: begin
            if (caminho_pronto_in) begin
              estado <= PRONTO;
            end
`ifdef CTRL_WATCHDOG_EN
            else if (wdt == WDT_LIMITE) begin
              estado   <= FALHA;
              erro_out <= ERR_WATCHDOG;
            end else begin
              wdt <= wdt + WDT_W'(1);
            end
`endif
          end
          PRONTO, FALHA: begin
            if (lido_in) estado <= IDLE;
          end
          default: estado <= IDLE;
        endcase
      end
    end
  end

  assign aguardando_out        = (estado == IDLE);
  assign iniciar_out           = (estado == INICIALIZAR);
  assign atualizar_buffer_out  = (estado == TEM_ATIVO) && aa_pronto_in && tem_ativo_in;
  assign construir_caminho_out = (estado == CONSTRUIR_CAMINHO);
  assign caminho_pronto_out    = (estado == PRONTO);
  assign falha_out             = (estado == FALHA);

endmodule

// File: tb/tb_controlador_maquina_estados_multi.sv
// Bench for controlador_maquina_estados_multi: vector table, directed corner cases
// and randomized searches against a round-level reference model.
module tb_controlador_maquina_estados_multi;

  localparam int NC   = 4;
  localparam int MAXI = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        iniciar_in = 0, abortar_in = 0, tem_ativo_in = 0, aa_pronto_in = 0;
  logic [7:0]  qtd_ativos_in = '0;
  logic        destino_encontrado_in = 0;
  logic [3:0]  lvv_pronto_in = '0;
  logic        caminho_pronto_in = 0, lido_in = 0;
  logic        aguardando_out, iniciar_out, atualizar_buffer_out;
  logic [3:0]  expandir_out;
  logic        construir_caminho_out, caminho_pronto_out, falha_out;
  logic [1:0]  erro_out;
  logic [15:0] iteracoes_out;

  int checks = 0;
  int failures = 0;
  int m_iter;
  int fin [4];

  typedef struct {
    int         qtd;
    bit         tem;
    bit         dest;
    logic [3:0] mask;
    int         kind;   // 0 expand, 1 build path, 2 failure
    logic [1:0] erro;
  } vec_t;
  vec_t tabela [9];

  controlador_maquina_estados_multi #(
    .NUM_CANAIS (NC), .CNT_WIDTH (8), .ITER_WIDTH (16), .MAX_ITER (MAXI), .WDT_CYCLES (16)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .iniciar_in            (iniciar_in),
    .abortar_in            (abortar_in),
    .tem_ativo_in          (tem_ativo_in),
    .aa_pronto_in          (aa_pronto_in),
    .qtd_ativos_in         (qtd_ativos_in),
    .destino_encontrado_in (destino_encontrado_in),
    .lvv_pronto_in         (lvv_pronto_in),
    .caminho_pronto_in     (caminho_pronto_in),
    .lido_in               (lido_in),
    .aguardando_out        (aguardando_out),
    .iniciar_out           (iniciar_out),
    .atualizar_buffer_out  (atualizar_buffer_out),
    .expandir_out          (expandir_out),
    .construir_caminho_out (construir_caminho_out),
    .caminho_pronto_out    (caminho_pronto_out),
    .falha_out             (falha_out),
    .erro_out              (erro_out),
    .iteracoes_out         (iteracoes_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", nome, atual, esperado);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_search();
    iniciar_in = 1; abortar_in = 0; aa_pronto_in = 0; tem_ativo_in = 0;
    destino_encontrado_in = 0; lvv_pronto_in = '0; caminho_pronto_in = 0; lido_in = 0;
    tick();
    iniciar_in = 0;
    #1 chk("ini_iniciar_out", iniciar_out, 1);
    chk("ini_iteracoes", iteracoes_out, 0);
    chk("ini_erro", erro_out, 0);
    aa_pronto_in = 1; tem_ativo_in = 1;
    tick();
    aa_pronto_in = 0; tem_ativo_in = 0;
    m_iter = 0;
  endtask

  // One expansion round from TEM_ATIVO; channel j (j < k) first finishes at cycle fin[j]
  // of EXPANDIR, so the round ends after the slowest one.
  task automatic expand_round(input int qtd, input bit ruido);
    int k;
    int ultimo;
    logic [3:0] m;
    logic [3:0] p;
    k = (qtd < 1) ? 1 : ((qtd > NC) ? NC : qtd);
    m = 4'((1 << k) - 1);
    ultimo = 0;
    for (int j = 0; j < k; j++) if (fin[j] > ultimo) ultimo = fin[j];
    aa_pronto_in = 1; tem_ativo_in = 1; qtd_ativos_in = 8'(qtd);
    destino_encontrado_in = 1'($urandom);
    #1 chk("rnd_atualizar_buffer", atualizar_buffer_out, 1);
    tick();
    aa_pronto_in = 1'($urandom);
    lvv_pronto_in = ruido ? 4'($urandom) : 4'b0;
    #1 chk("rnd_expandir_antes", expandir_out, 0);
    chk("rnd_atualizar_um_ciclo", atualizar_buffer_out, 0);
    tick();
    for (int c = 0; c <= ultimo; c++) begin
      for (int j = 0; j < NC; j++) begin
        if (j < k) p[j] = (c == fin[j]) || (c > fin[j] && ruido && $urandom_range(0, 1) == 1);
        else       p[j] = ruido && (c == 1 || $urandom_range(0, 1) == 1);
      end
      lvv_pronto_in = p; aa_pronto_in = 1; tem_ativo_in = 1;
      #1 chk("rnd_expandir_pulso", expandir_out, (c == 0) ? m : 4'b0);
      chk("rnd_espera_canais", atualizar_buffer_out, 0);
      chk("rnd_iteracoes_durante", iteracoes_out, m_iter);
      tick();
    end
    lvv_pronto_in = '0;
    m_iter++;
    #1 chk("rnd_iteracoes_fim", iteracoes_out, m_iter);
    if (m_iter == MAXI) begin
      chk("rnd_limite_falha", falha_out, 1);
      chk("rnd_limite_erro", erro_out, 2);
    end else begin
      chk("rnd_volta_tem_ativo", atualizar_buffer_out, 1);
    end
  endtask

  initial begin
    int rondas, ociosos, term, esp_erro, espera;
    bit abortado;

    tabela[0] = '{0,   1'b1, 1'b0, 4'b0001, 0, 2'd0};
    tabela[1] = '{1,   1'b1, 1'b1, 4'b0001, 0, 2'd0};
    tabela[2] = '{2,   1'b1, 1'b0, 4'b0011, 0, 2'd0};
    tabela[3] = '{3,   1'b1, 1'b0, 4'b0111, 0, 2'd0};
    tabela[4] = '{4,   1'b1, 1'b1, 4'b1111, 0, 2'd0};
    tabela[5] = '{9,   1'b1, 1'b0, 4'b1111, 0, 2'd0};
    tabela[6] = '{255, 1'b1, 1'b0, 4'b1111, 0, 2'd0};
    tabela[7] = '{5,   1'b0, 1'b1, 4'b0000, 1, 2'd0};
    tabela[8] = '{5,   1'b0, 1'b0, 4'b0000, 2, 2'd1};

    // Reset values
    tick(); tick();
    #1 chk("rst_aguardando", aguardando_out, 1);
    chk("rst_iniciar_out", iniciar_out, 0);
    chk("rst_expandir", expandir_out, 0);
    chk("rst_erro", erro_out, 0);
    chk("rst_iteracoes", iteracoes_out, 0);
    chk("rst_falha", falha_out, 0);
    chk("rst_construir", construir_caminho_out, 0);
    chk("rst_caminho_pronto", caminho_pronto_out, 0);
    chk("rst_atualizar", atualizar_buffer_out, 0);
    tick();
    rst_n = 0;
    tick();
    #1 chk("idle_mantem", aguardando_out, 1);

    // Vector table: one decision from TEM_ATIVO
    for (int i = 0; i < 9; i++) begin
      start_search();
      aa_pronto_in = 1; tem_ativo_in = tabela[i].tem;
      destino_encontrado_in = tabela[i].dest; qtd_ativos_in = 8'(tabela[i].qtd);
      #1 chk("tab_atualizar", atualizar_buffer_out, tabela[i].tem);
      tick();
      if (tabela[i].kind == 0) begin
        #1 chk("tab_expandir_cedo", expandir_out, 0);
        tick();
        #1 chk("tab_mascara", expandir_out, tabela[i].mask);
        lvv_pronto_in = 4'hF;
        tick();
        lvv_pronto_in = '0;
        #1 chk("tab_iteracoes", iteracoes_out, 1);
        chk("tab_expandir_fim", expandir_out, 0);
        chk("tab_volta_tem_ativo", atualizar_buffer_out, 1);
      end else if (tabela[i].kind == 1) begin
        #1 chk("tab_construir", construir_caminho_out, 1);
        chk("tab_construir_erro", erro_out, tabela[i].erro);
      end else begin
        #1 chk("tab_falha", falha_out, 1);
        chk("tab_falha_erro", erro_out, tabela[i].erro);
      end
    end

    // iniciar_in beats abortar_in (DUT currently in FALHA)
    iniciar_in = 1; abortar_in = 1; aa_pronto_in = 0;
    tick();
    iniciar_in = 0; abortar_in = 0;
    #1 chk("prio_iniciar", iniciar_out, 1);
    chk("prio_erro_limpo", erro_out, 0);

    // Staggered channel completion, qtd=3, channel 3 pulses ignored
    start_search();
    fin[0] = 2; fin[1] = 5; fin[2] = 3; fin[3] = 0;
    expand_round(3, 1'b1);

    // Path construction with delayed caminho_pronto_in
    start_search();
    aa_pronto_in = 1; tem_ativo_in = 0; destino_encontrado_in = 1;
    tick();
    aa_pronto_in = 0;
    for (int w = 0; w < 5; w++) begin
      #1 chk("cam_construir", construir_caminho_out, 1);
      chk("cam_pronto_cedo", caminho_pronto_out, 0);
      tick();
    end
    caminho_pronto_in = 1;
    tick();
    caminho_pronto_in = 0;
    for (int w = 0; w < 3; w++) begin
      #1 chk("cam_pronto_mantem", caminho_pronto_out, 1);
      chk("cam_erro", erro_out, 0);
      tick();
    end
    lido_in = 1;
    tick();
    lido_in = 0;
    #1 chk("cam_lido_idle", aguardando_out, 1);

    // No path: error 1 survives lido_in, cleared by iniciar_in
    start_search();
    aa_pronto_in = 1; tem_ativo_in = 0; destino_encontrado_in = 0;
    tick();
    aa_pronto_in = 0;
    #1 chk("sem_falha", falha_out, 1);
    chk("sem_erro", erro_out, 1);
    lido_in = 1;
    tick();
    lido_in = 0;
    #1 chk("sem_idle", aguardando_out, 1);
    chk("sem_erro_mantem", erro_out, 1);
    iniciar_in = 1;
    tick();
    iniciar_in = 0;
    #1 chk("sem_erro_limpo", erro_out, 0);

    // Iteration limit after MAXI rounds
    start_search();
    for (int r = 0; r < MAXI; r++) begin
      for (int j = 0; j < NC; j++) fin[j] = $urandom_range(0, 3);
      expand_round($urandom_range(1, 6), 1'b0);
    end
    lido_in = 1;
    tick();
    lido_in = 0;
    #1 chk("lim_idle", aguardando_out, 1);
    chk("lim_iteracoes_mantem", iteracoes_out, MAXI);
    chk("lim_erro_mantem", erro_out, 2);

    // Abort mid-EXPANDIR
    start_search();
    aa_pronto_in = 1; tem_ativo_in = 1; qtd_ativos_in = 8'd2;
    tick(); tick();
    #1 chk("abt_mascara", expandir_out, 4'b0011);
    abortar_in = 1;
    tick();
    abortar_in = 0;
    #1 chk("abt_idle", aguardando_out, 1);
    chk("abt_expandir", expandir_out, 0);
    chk("abt_erro", erro_out, 0);

    // Asynchronous reset mid-EXPANDIR clears counters at once
    start_search();
    for (int j = 0; j < NC; j++) fin[j] = 0;
    expand_round(4, 1'b0);
    qtd_ativos_in = 8'd2;
    tick(); tick();
    #1 chk("arst_mascara", expandir_out, 4'b0011);
    #2 rst_n = 1;
    #1 chk("arst_idle", aguardando_out, 1);
    chk("arst_expandir", expandir_out, 0);
    chk("arst_iteracoes", iteracoes_out, 0);
    tick();
    rst_n = 0;

`ifdef CTRL_WATCHDOG_EN
    // Channel 1 never finishes: watchdog fires 16 cycles after EXPANDIR entry
    start_search();
    aa_pronto_in = 1; tem_ativo_in = 1; qtd_ativos_in = 8'd2;
    tick(); tick();
    for (int c = 0; c < 16; c++) begin
      lvv_pronto_in = (c == 0) ? 4'b0001 : 4'b0000;
      #1 chk("wdt_ainda_expandindo", falha_out, 0);
      tick();
    end
    lvv_pronto_in = '0;
    #1 chk("wdt_falha", falha_out, 1);
    chk("wdt_erro", erro_out, 3);
`endif

    // Randomized searches against the round-level model
    for (int s = 0; s < 30; s++) begin
      start_search();
      abortado = 0;
      esp_erro = 0;
      rondas = $urandom_range(0, MAXI);
      for (int r = 0; r < rondas; r++) begin
        ociosos = $urandom_range(0, 2);
        for (int w = 0; w < ociosos; w++) begin
          aa_pronto_in = 0; tem_ativo_in = 1'($urandom); lvv_pronto_in = 4'($urandom);
          #1 chk("rnd_ocioso", atualizar_buffer_out, 0);
          tick();
        end
        lvv_pronto_in = '0;
        for (int j = 0; j < NC; j++) fin[j] = $urandom_range(0, 5);
        expand_round($urandom_range(0, 9), 1'b1);
      end
      if (m_iter == MAXI) begin
        esp_erro = 2;
      end else begin
        term = $urandom_range(0, 2);
        if (term == 0) begin
          aa_pronto_in = 1; tem_ativo_in = 0; destino_encontrado_in = 1;
          tick();
          aa_pronto_in = 0;
          espera = $urandom_range(0, 4);
          for (int w = 0; w < espera; w++) begin
            #1 chk("rnd_construir", construir_caminho_out, 1);
            tick();
          end
          caminho_pronto_in = 1;
          tick();
          caminho_pronto_in = 0;
          #1 chk("rnd_caminho_pronto", caminho_pronto_out, 1);
          esp_erro = 0;
        end else if (term == 1) begin
          aa_pronto_in = 1; tem_ativo_in = 0; destino_encontrado_in = 0;
          tick();
          aa_pronto_in = 0;
          #1 chk("rnd_sem_caminho", falha_out, 1);
          esp_erro = 1;
        end else begin
          abortar_in = 1;
          tick();
          abortar_in = 0;
          #1 chk("rnd_abort_idle", aguardando_out, 1);
          chk("rnd_abort_erro", erro_out, 0);
          chk("rnd_abort_iteracoes", iteracoes_out, m_iter);
          abortado = 1;
        end
      end
      if (!abortado) begin
        lido_in = 1;
        tick();
        lido_in = 0;
        #1 chk("rnd_lido_idle", aguardando_out, 1);
        chk("rnd_erro_final", erro_out, esp_erro);
        chk("rnd_iteracoes_final", iteracoes_out, m_iter);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controlador_maquina_estados_multi.md
# controlador_maquina_estados_multi

Top-level sequencing FSM for the path-search datapath, parametrised successor of the single-expander controller. It drives the active-node evaluator (AA) and buffer updates, and dispatches expansion to NUM_CANAIS parallel neighbour-expansion (LVV) channels. It waits for every dispatched channel to finish, then triggers path construction. It adds an iteration limit, a no-path/failure exit, an abort input and an error code.

## Interface
Parameters:
- NUM_CANAIS, 4, number of parallel LVV expansion channels (1..16)
- CNT_WIDTH, 8, width of qtd_ativos_in
- ITER_WIDTH, 16, width of the iteration counter
- MAX_ITER, 1000, completed expansion rounds before forced failure (≥1, < 2^ITER_WIDTH)
- WDT_CYCLES, 4096, watchdog limit; used only with CTRL_WATCHDOG_EN

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-high reset (asserted = 1); name kept per codebase convention
- iniciar_in  in  1  start a search; highest priority, any state
- abortar_in  in  1  return to IDLE; second priority
- tem_ativo_in  in  1  AA holds at least one active node
- aa_pronto_in  in  1  AA result valid
- qtd_ativos_in  in  CNT_WIDTH  number of active nodes available for dispatch
- destino_encontrado_in  in  1  destination has been reached/closed
- lvv_pronto_in  in  NUM_CANAIS  per-channel expansion-done pulse or level
- caminho_pronto_in  in  1  path builder finished
- lido_in  in  1  host has read the result
- aguardando_out  out  1  state == IDLE
- iniciar_out  out  1  state == INICIALIZAR
- atualizar_buffer_out  out  1  state == TEM_ATIVO && aa_pronto_in && tem_ativo_in (combinational)
- expandir_out  out  NUM_CANAIS  registered one-cycle per-channel start pulse
- construir_caminho_out  out  1  state == CONSTRUIR_CAMINHO
- caminho_pronto_out  out  1  state == PRONTO
- falha_out  out  1  state == FALHA
- erro_out  out  2  0 none, 1 no path, 2 iteration limit, 3 watchdog; registered
- iteracoes_out  out  ITER_WIDTH  completed expansion rounds; registered

## Operation
- States: IDLE, INICIALIZAR, TEM_ATIVO, ATUALIZAR_BUFFER, EXPANDIR, CONSTRUIR_CAMINHO, PRONTO, FALHA.
- iniciar_in forces INICIALIZAR from any state. It clears iteracoes_out, erro_out, the channel mask and done flags. Otherwise abortar_in forces IDLE, with no error recorded.
- INICIALIZAR → TEM_ATIVO when aa_pronto_in && tem_ativo_in.
- TEM_ATIVO, when aa_pronto_in:
  - tem_ativo_in → ATUALIZAR_BUFFER. Latch mask = lowest k bits set, k = min(max(qtd_ativos_in,1), NUM_CANAIS).
  - !tem_ativo_in && destino_encontrado_in → CONSTRUIR_CAMINHO.
  - otherwise → FALHA with erro=1.
- ATUALIZAR_BUFFER: one cycle, then → EXPANDIR. Registers expandir_out <= mask.
- EXPANDIR:
  - Per-channel sticky done flags capture lvv_pronto_in, including in the first EXPANDIR cycle.
  - Bits outside the mask are ignored.
  - When (done | lvv_pronto_in) & mask == mask: iteracoes_out increments. Then → FALHA with erro=2 if the new value == MAX_ITER, else → TEM_ATIVO. Done flags clear.
- CONSTRUIR_CAMINHO → PRONTO on caminho_pronto_in.
- PRONTO / FALHA → IDLE on lido_in. erro_out and iteracoes_out hold until the next iniciar_in.

## Timing
- Reset values:
  - state = IDLE, so aguardando_out=1.
  - expandir_out=0, erro_out=0, iteracoes_out=0, falha_out=0.
  - All other outputs are 0.
- State transitions take effect on the clock edge after the condition is sampled.
- expandir_out is high for exactly one cycle: the first EXPANDIR cycle, 1 cycle after the ATUALIZAR_BUFFER entry.
- Best-case round, all channels done in the first EXPANDIR cycle: TEM_ATIVO → ATUALIZAR_BUFFER → EXPANDIR → TEM_ATIVO is 3 cycles.
- Channels may finish in any order or simultaneously. A channel pulsing repeatedly is counted once.
- The iteracoes_out increment is visible in the same cycle the state leaves EXPANDIR.
- Reset mid-search returns to IDLE immediately, asynchronously. No partial counters survive.
- iniciar_in and abortar_in asserted in the same cycle: iniciar_in wins.

## Configuration
- CTRL_WATCHDOG_EN defined:
  - A WDT counter of width $clog2(WDT_CYCLES+1) resets on every state change.
  - It counts in EXPANDIR and CONSTRUIR_CAMINHO.
  - Reaching WDT_CYCLES → FALHA with erro=3.
- Not defined: no counter is built, erro value 3 is never produced, and WDT_CYCLES is unused.

## Structure
- Package ctrl_pkg:
  - state enum constants (3-bit encoding listed order 0..7)
  - erro code localparams (ERR_NONE, ERR_SEM_CAMINHO, ERR_LIMITE_ITER, ERR_WATCHDOG)
- Sub-module coletor_canais (parameter NUM_CANAIS):
  - inputs clear, enable, mask, lvv_pronto_in
  - holds the sticky done flags and produces todos_prontos
- FSM, counters and output registers stay in the top.

## Test plan
- NUM_CANAIS=4, qtd_ativos_in=3: one round with channels 0,1,2 done on cycles +2,+5,+3 → expandir_out=4'b0111 for one cycle; return to TEM_ATIVO one cycle after cycle +5; iteracoes_out=1. A pulse on channel 3 is ignored.
- qtd_ativos_in=9, NUM_CANAIS=4 → mask 4'b1111. qtd_ativos_in=0 with tem_ativo_in=1 → mask 4'b0001.
- tem_ativo_in=0, destino_encontrado_in=1, caminho_pronto_in after 5 cycles → CONSTRUIR_CAMINHO then PRONTO; caminho_pronto_out=1 until lido_in; erro_out=0.
- tem_ativo_in=0, destino_encontrado_in=0 → falha_out=1, erro_out=1. lido_in → aguardando_out=1, erro_out still 1. iniciar_in → erro_out=0.
- MAX_ITER=3, AA always active → third completed round enters FALHA with erro_out=2, iteracoes_out=3.
- With CTRL_WATCHDOG_EN and WDT_CYCLES=16: channel 1 never finishes → FALHA with erro_out=3 exactly 16 cycles after EXPANDIR entry. Reset or abortar_in mid-EXPANDIR → IDLE, expandir_out=0.
